// File: rtl/uart_axis_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_axis_pkg : shared FSM encoding, divider function and frame constants |
// | for the AXI-stream UART transmitter. UART_AXIS_PARITY_EN selects 8E1.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int c_data_bits      = 8;
  localparam int c_frame_bits_8n1 = 10;
  localparam int c_frame_bits_8e1 = 11;
`ifdef UART_AXIS_PARITY_EN
  localparam int c_frame_bits     = c_frame_bits_8e1;
`else
  localparam int c_frame_bits     = c_frame_bits_8n1;
`endif

  // Rounded clock-cycles-per-bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_axis_if.sv
// +----------------------------------------------------------------------------+
// | uart_axis_if : byte-wide AXI-stream handshake bundle with master/slave    |
// | modports.                                                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_axis_if import uart_axis_pkg::*; ();

  logic                   tvalid;
  logic [c_data_bits-1:0] tdata;
  logic                   tready;

  modport master (output tvalid, output tdata, input  tready);
  modport slave  (input  tvalid, input  tdata, output tready);

endinterface

`default_nettype wire

// File: rtl/axis_byte_fifo.sv
// +----------------------------------------------------------------------------+
// | axis_byte_fifo : synchronous FIFO with occupancy count, async reset.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module axis_byte_fifo import uart_axis_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int WIDTH = c_data_bits
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_i,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_wdata,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == (c_ptr_w + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_axis.sv
// +----------------------------------------------------------------------------+
// | uart_tx_axis : AXI-stream slave UART transmitter, FIFO-buffered 8N1       |
// | (8E1 when UART_AXIS_PARITY_EN is defined). Rev 1.0                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_axis import uart_axis_pkg::*; #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic                          clk_i,
  input  wire logic                          rst_i,
  uart_axis_if.slave                         s_axis,
  output logic                               uart_tx_o,
  output logic                               busy_o,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count_o
);

  localparam int c_div    = calc_div(CLK_FREQ, BAUD);
  localparam int c_baud_w = (c_div > 1) ? $clog2(c_div) : 1;

  uart_state_t              r_state;
  uart_state_t              w_state_nxt;
  logic [c_baud_w-1:0]      r_baud;
  logic [2:0]               r_bit_idx;
  logic [c_data_bits-1:0]   r_shreg;
  logic                     r_tx;
  logic                     w_bit_end;
  logic                     w_pop;
  logic                     w_shift;
  logic                     w_line;
  logic                     w_full;
  logic                     w_empty;
  logic [c_data_bits-1:0]   w_fifo_rdata;
`ifdef UART_AXIS_PARITY_EN
  logic                     r_parity;
`endif

  assign s_axis.tready = ~rst_i & ~w_full;
  assign busy_o        = (r_state != ST_IDLE) | ~w_empty;
  assign uart_tx_o     = r_tx;
  assign w_bit_end     = (r_baud == c_baud_w'(c_div - 1));

  axis_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_data_bits)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (s_axis.tvalid & s_axis.tready),
    .i_wdata (s_axis.tdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count_o)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_line      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_line = 1'b0;
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_line = r_shreg[0];
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'(c_data_bits - 1)) begin
`ifdef UART_AXIS_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_AXIS_PARITY_EN
      ST_PARITY: begin
        w_line = r_parity;
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit so frames abut.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // State only changes on a bit end (or out of IDLE), so this reloads on entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
    end else begin
      if (r_state == ST_IDLE || w_bit_end) r_baud <= '0;
      else                                 r_baud <= r_baud + 1'b1;

      if (r_state != ST_DATA) r_bit_idx <= '0;
      else if (w_shift)       r_bit_idx <= r_bit_idx + 1'b1;

      if (w_pop)        r_shreg <= w_fifo_rdata;
      else if (w_shift) r_shreg <= {1'b0, r_shreg[c_data_bits-1:1]};

      r_tx <= w_line;
    end
  end

`ifdef UART_AXIS_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_fifo_rdata;
    end
  end
`endif

endmodule

`default_nettype wire
